// File: rtl/led_seq_pkg.sv
// Shared definitions for the LED sequencer.
// Holds the pattern mode encodings (these match the cfg_mode port values),
// the controller state encodings, and a small helper that tells whether a
// mode's first frame has LED 0 lit.
package led_seq_pkg;

  typedef enum logic [1:0] {
    MODE_CHASE  = 2'b00,
    MODE_BOUNCE = 2'b01,
    MODE_FILL   = 2'b10,
    MODE_BLINK  = 2'b11
  } mode_t;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_RUN   = 2'b01,
    ST_PAUSE = 2'b10
  } state_t;

  // Chase and bounce start with a single lit LED at position 0; fill and
  // blink start dark.
  function automatic logic starts_lit(mode_t m);
    return (m == MODE_CHASE) || (m == MODE_BOUNCE);
  endfunction

endpackage

// File: rtl/tick_gen.sv
// Step-rate counter for the LED sequencer.
// Ports:
//   clk    - rising-edge clock
//   rst    - asynchronous active-low reset
//   en     - count this cycle
//   clr    - synchronous clear (wins over en)
//   period - cycles per step, must be >= 1
//   pulse  - high in the cycle whose edge wraps the counter back to 0
module tick_gen #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             clr,
  input  logic [WIDTH-1:0] period,
  output logic             pulse
);

  localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1};

  logic [WIDTH-1:0] count;
  logic             at_end;

  // Using >= rather than == keeps the counter from running away if it is
  // ever above the last value (period is only changed together with clr).
  assign at_end = (count >= (period - ONE));
  assign pulse  = en && at_end;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (en) begin
      count <= at_end ? '0 : (count + ONE);
    end
  end

endmodule

// File: rtl/led_seq_ctrl.sv
// LED pattern sequencer.
// Steps a chase / bounce / fill / blink pattern across N_LED outputs at a
// programmable rate, with run/pause control and single-stepping while paused.
// Ports:
//   clk        - rising-edge clock
//   rst        - asynchronous active-low reset
//   cfg_valid  - configuration request
//   cfg_ready  - configuration accept (high outside RUN)
//   cfg_mode   - pattern select: 00 chase, 01 bounce, 10 fill, 11 blink
//   cfg_period - clk cycles per pattern step (0 is treated as 1)
//   run        - level enable
//   step       - single-step pulse, only acted on while paused
//   led        - registered LED drive
//   tick       - one-cycle pulse after each pattern advance
//   busy       - high while running
module led_seq_ctrl
  import led_seq_pkg::*;
#(
  parameter int          WIDTH      = 32,
  parameter int          N_LED      = 4,
  parameter int unsigned DEF_PERIOD = 500_000
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cfg_valid,
  output logic             cfg_ready,
  input  logic [1:0]       cfg_mode,
  input  logic [WIDTH-1:0] cfg_period,
  input  logic             run,
  input  logic             step,
  output logic [N_LED-1:0] led,
  output logic             tick,
  output logic             busy
);

  localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1};

  function automatic logic [N_LED-1:0] init_pattern(mode_t m);
    logic [N_LED-1:0] p;
    p    = '0;
    p[0] = starts_lit(m);
    return p;
  endfunction

  function automatic logic [N_LED-1:0] next_pattern(mode_t m, logic [N_LED-1:0] p, logic up);
    logic [N_LED-1:0] n;
    n = p;
    case (m)
      MODE_CHASE:  n = {p[N_LED-2:0], p[N_LED-1]};
      MODE_BOUNCE: n = up ? (p << 1) : (p >> 1);
      MODE_FILL:   n = (&p) ? '0 : {p[N_LED-2:0], 1'b1};
      MODE_BLINK:  n = ~p;
      default:     n = p;
    endcase
    return n;
  endfunction

  // Bounce turns around when the step it is about to take lands on an end,
  // so the end position is shown once and not repeated.
  function automatic logic next_dir(mode_t m, logic [N_LED-1:0] p, logic up);
    logic d;
    d = up;
    if (m == MODE_BOUNCE) begin
      d = up ? ~p[N_LED-2] : p[1];
    end
    return d;
  endfunction

  state_t           state;
  mode_t            mode;
  logic [WIDTH-1:0] period;
  logic             dir_up;

  logic             xfer;
  mode_t            new_mode;
  logic [WIDTH-1:0] new_period;
  logic [N_LED-1:0] adv_pattern;
  logic             adv_dir;
  logic             cnt_en;
  logic             cnt_clr;
  logic             cnt_pulse;

  assign xfer        = cfg_valid && cfg_ready;
  assign new_mode    = mode_t'(cfg_mode);
  assign new_period  = (cfg_period == '0) ? ONE : cfg_period;
  assign adv_pattern = next_pattern(mode, led, dir_up);
  assign adv_dir     = next_dir(mode, led, dir_up);

  // Count only on edges where the sequencer stays in RUN, so dropping run
  // freezes the count at the value it had when run fell.
  assign cnt_en  = (state == ST_RUN) && run;
  assign cnt_clr = (state == ST_IDLE) || ((state == ST_PAUSE) && xfer);

  tick_gen #(
    .WIDTH(WIDTH)
  ) u_tick_gen (
    .clk   (clk),
    .rst   (rst),
    .en    (cnt_en),
    .clr   (cnt_clr),
    .period(period),
    .pulse (cnt_pulse)
  );

  // led is the pattern register itself; it stays 0 in IDLE because it is
  // only loaded on the way into RUN. cfg_ready and busy are registered
  // alongside the state so they always agree with it.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= ST_IDLE;
      mode      <= MODE_CHASE;
      period    <= WIDTH'(DEF_PERIOD);
      led       <= '0;
      dir_up    <= 1'b1;
      tick      <= 1'b0;
      busy      <= 1'b0;
      cfg_ready <= 1'b1;
    end else begin
      tick <= 1'b0;
      unique case (state)
        ST_IDLE: begin
          if (xfer) begin
            mode   <= new_mode;
            period <= new_period;
          end
          if (run) begin
            state     <= ST_RUN;
            led       <= init_pattern(xfer ? new_mode : mode);
            dir_up    <= 1'b1;
            busy      <= 1'b1;
            cfg_ready <= 1'b0;
          end
        end
        ST_RUN: begin
          if (!run) begin
            state     <= ST_PAUSE;
            busy      <= 1'b0;
            cfg_ready <= 1'b1;
          end else if (cnt_pulse) begin
            led    <= adv_pattern;
            dir_up <= adv_dir;
            tick   <= 1'b1;
          end
        end
        ST_PAUSE: begin
          // A config transfer restarts the pattern and swallows any step
          // or run request in the same cycle.
          if (xfer) begin
            mode   <= new_mode;
            period <= new_period;
            led    <= init_pattern(new_mode);
            dir_up <= 1'b1;
          end else if (run) begin
            state     <= ST_RUN;
            busy      <= 1'b1;
            cfg_ready <= 1'b0;
          end else if (step) begin
            led    <= adv_pattern;
            dir_up <= adv_dir;
            tick   <= 1'b1;
          end
        end
        default: begin
          state     <= ST_IDLE;
          led       <= '0;
          busy      <= 1'b0;
          cfg_ready <= 1'b1;
        end
      endcase
    end
  end

endmodule
